// File: rtl/s832_resp_misr_if.sv
// Response/control bundle between a test harness and the s832 response compactor.
// With S832_RESP_XMASK_EN defined the bundle also carries a per-vector X mask.
interface s832_resp_misr_if #(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned SIG_W = 24,
    parameter int unsigned CNT_W = 16
) ();
    logic             start;
    logic [CNT_W-1:0] num_vectors;
    logic [SIG_W-1:0] golden;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_data;
`ifdef S832_RESP_XMASK_EN
    logic [WIDTH-1:0] resp_mask;
`endif
    logic             resp_ready;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] signature;
    logic [CNT_W-1:0] vec_count;

`ifdef S832_RESP_XMASK_EN
    modport master (
        output start, num_vectors, golden, resp_valid, resp_data, resp_mask,
        input  resp_ready, busy, done, pass, signature, vec_count
    );
    modport slave (
        input  start, num_vectors, golden, resp_valid, resp_data, resp_mask,
        output resp_ready, busy, done, pass, signature, vec_count
    );
`else
    modport master (
        output start, num_vectors, golden, resp_valid, resp_data,
        input  resp_ready, busy, done, pass, signature, vec_count
    );
    modport slave (
        input  start, num_vectors, golden, resp_valid, resp_data,
        output resp_ready, busy, done, pass, signature, vec_count
    );
`endif
endinterface

// File: rtl/s832_resp_misr.sv
// MISR response compactor for the s832 core: folds N output vectors into a signature
// and compares it with a golden value. Optional X masking via S832_RESP_XMASK_EN.
module s832_resp_misr #(
    parameter int unsigned     WIDTH = 19,
    parameter int unsigned     SIG_W = 24,
    parameter logic [SIG_W-1:0] POLY = 24'hC20001,
    parameter logic [SIG_W-1:0] SEED = 24'h000000,
    parameter int unsigned     CNT_W = 16
) (
    input logic               blif_clk_net,
    input logic               blif_reset_net,
    s832_resp_misr_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_COLLECT = 3'd2,
        S_CHECK   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [SIG_W-1:0] gold_q, gold_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic             accept_c;
    logic [WIDTH-1:0] vec_c;
    logic [SIG_W-1:0] misr_next_c;
    logic [CNT_W-1:0] cnt_inc_c;

    // Masked bits are forced to 0 so unknown core outputs cannot corrupt the signature
`ifdef S832_RESP_XMASK_EN
    assign vec_c = bus.resp_data & ~bus.resp_mask;
`else
    assign vec_c = bus.resp_data;
`endif

    assign accept_c    = bus.resp_valid & ready_q;
    assign misr_next_c = {sig_q[SIG_W-2:0], 1'b0}
                       ^ (sig_q[SIG_W-1] ? POLY : {SIG_W{1'b0}})
                       ^ SIG_W'(vec_c);
    assign cnt_inc_c   = cnt_q + CNT_W'(1);

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        gold_d  = gold_q;
        done_d  = done_q;
        pass_d  = pass_q;
        ready_d = 1'b0;
        busy_d  = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    num_d   = bus.num_vectors;
                    gold_d  = bus.golden;
                    sig_d   = SEED;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                state_d = (num_q == '0) ? S_CHECK : S_COLLECT;
            end
            S_COLLECT: begin
                if (accept_c) begin
                    sig_d = misr_next_c;
                    cnt_d = cnt_inc_c;
                    if (cnt_inc_c == num_q) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                pass_d  = (sig_q == gold_q);
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered copies of the state being entered
        ready_d = (state_d == S_COLLECT);
        busy_d  = (state_d == S_ARM) || (state_d == S_COLLECT) || (state_d == S_CHECK);
    end

    // State and output registers
    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            state_q <= S_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            num_q   <= '0;
            gold_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            gold_q  <= gold_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.resp_ready = ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.signature  = sig_q;
    assign bus.vec_count  = cnt_q;

endmodule

// File: tb/tb_s832_resp_misr.sv
// Scoreboard bench for s832_resp_misr: expected signatures come from a reference MISR model.
// Define S832_RESP_XMASK_EN for both RTL and bench to cover the X-mask build.
module tb_s832_resp_misr;

    localparam logic [23:0] POLY  = 24'hC20001;
    localparam logic [23:0] SEED0 = 24'h000000;
    localparam logic [23:0] SEED1 = 24'h800000;

    logic blif_clk_net = 1'b0;
    logic blif_reset_net;
    always #5 blif_clk_net = ~blif_clk_net;

    s832_resp_misr_if bus  ();
    s832_resp_misr_if bus2 ();

    s832_resp_misr dut (
        .blif_clk_net   (blif_clk_net),
        .blif_reset_net (blif_reset_net),
        .bus            (bus)
    );

    s832_resp_misr #(.SEED(SEED1)) dut_seed (
        .blif_clk_net   (blif_clk_net),
        .blif_reset_net (blif_reset_net),
        .bus            (bus2)
    );

    typedef struct {
        logic [23:0] sig;
        logic [15:0] cnt;
        logic        pass;
    } exp_t;

    exp_t        sb[$];
    logic [18:0] vecs[$];
    logic [18:0] masks[$];
    int          checks   = 0;
    int          failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] misr_step(input logic [23:0] s, input logic [18:0] v);
        logic [23:0] r;
        r = {s[22:0], 1'b0};
        if (s[23]) r = r ^ POLY;
        r = r ^ {5'b0, v};
        return r;
    endfunction

    function automatic logic [23:0] model_sig(input int n, input logic [23:0] seed);
        logic [23:0] s;
        s = seed;
        for (int i = 0; i < n; i++) s = misr_step(s, vecs[i] & ~masks[i]);
        return s;
    endfunction

    task automatic set_vecs(input int n, input bit rnd, input logic [18:0] val);
        vecs.delete();
        masks.delete();
        for (int i = 0; i < n; i++) begin
            vecs.push_back(rnd ? 19'($urandom) : val);
            masks.push_back(19'h0);
        end
    endtask

    // Present one vector and wait (bounded) for it to be accepted
    task automatic accept_one(input logic [18:0] v, input logic [18:0] m, output bit ok);
        int t;
        bus.resp_valid = 1'b1;
        bus.resp_data  = v;
`ifdef S832_RESP_XMASK_EN
        bus.resp_mask  = m;
`else
        if (m != 19'h0) $display("note: mask ignored in this build");
`endif
        t = 0;
        while (!bus.resp_ready && t < 20) begin
            @(negedge blif_clk_net);
            t++;
        end
        ok = bus.resp_ready;
        if (!ok) check_val("ready_timeout", 32'(bus.resp_ready), 32'd1);
        @(negedge blif_clk_net);
        bus.resp_valid = 1'b0;
    endtask

    task automatic run_vecs(input int n, input logic [23:0] gold, input int gap_after, input bit poke);
        exp_t        e;
        exp_t        got;
        logic [23:0] s;
        bit          ok;
        int          t;
        int          lat_exp;

        e.sig  = model_sig(n, SEED0);
        e.cnt  = 16'(n);
        e.pass = (e.sig == gold);
        sb.push_back(e);

        @(negedge blif_clk_net);
        bus.start       = 1'b1;
        bus.num_vectors = 16'(n);
        bus.golden      = gold;
        @(negedge blif_clk_net);
        bus.start = 1'b0;
        check_val("arm_busy", 32'(bus.busy), 32'd1);
        check_val("arm_ready", 32'(bus.resp_ready), 32'd0);
        check_val("arm_pass", 32'(bus.pass), 32'd0);
        check_val("arm_done", 32'(bus.done), 32'd0);

        s = SEED0;
        for (int i = 0; i < n; i++) begin
            accept_one(vecs[i], masks[i], ok);
            if (!ok) break;
            s = misr_step(s, vecs[i] & ~masks[i]);
            check_val($sformatf("sig_v%0d", i), 32'(bus.signature), 32'(s));
            check_val($sformatf("cnt_v%0d", i), 32'(bus.vec_count), 32'(i + 1));
            if (i == gap_after) begin
                for (int g = 0; g < 10; g++) begin
                    bus.start       = poke && (g == 0);
                    bus.num_vectors = 16'd0;
                    @(negedge blif_clk_net);
                end
                bus.start = 1'b0;
                check_val("gap_cnt", 32'(bus.vec_count), 32'(i + 1));
                check_val("gap_ready", 32'(bus.resp_ready), 32'd1);
                check_val("gap_busy", 32'(bus.busy), 32'd1);
                check_val("gap_sig", 32'(bus.signature), 32'(s));
            end
        end

        t = 0;
        while (!bus.done && t < 10) begin
            check_val("ready_after_last", 32'(bus.resp_ready), 32'd0);
            @(negedge blif_clk_net);
            t++;
        end
        lat_exp = (n == 0) ? 2 : 1;
        check_val("done_latency", 32'(t), 32'(lat_exp));

        if (sb.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check_val("done", 32'(bus.done), 32'd1);
            check_val("final_sig", 32'(bus.signature), 32'(got.sig));
            check_val("final_cnt", 32'(bus.vec_count), 32'(got.cnt));
            check_val("final_pass", 32'(bus.pass), 32'(got.pass));
            check_val("final_busy", 32'(bus.busy), 32'd0);
        end
        @(negedge blif_clk_net);
        check_val("done_held", 32'(bus.done), 32'd1);
        check_val("sig_held", 32'(bus.signature), 32'(e.sig));
    endtask

    initial begin
        bit          ok;
        int          t;
        logic [23:0] g;

        blif_reset_net   = 1'b1;
        bus.start        = 1'b0;
        bus.num_vectors  = '0;
        bus.golden       = '0;
        bus.resp_valid   = 1'b0;
        bus.resp_data    = '0;
        bus2.start       = 1'b0;
        bus2.num_vectors = '0;
        bus2.golden      = '0;
        bus2.resp_valid  = 1'b0;
        bus2.resp_data   = '0;
`ifdef S832_RESP_XMASK_EN
        bus.resp_mask    = '0;
        bus2.resp_mask   = '0;
`endif
        repeat (3) @(negedge blif_clk_net);
        check_val("rst_ready", 32'(bus.resp_ready), 32'd0);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_done", 32'(bus.done), 32'd0);
        check_val("rst_pass", 32'(bus.pass), 32'd0);
        check_val("rst_sig", 32'(bus.signature), 32'(SEED0));
        check_val("rst_cnt", 32'(bus.vec_count), 32'd0);
        check_val("rst_sig_seed1", 32'(bus2.signature), 32'(SEED1));
        blif_reset_net = 1'b0;

        // Single vector, matching golden
        set_vecs(1, 1'b0, 19'h00001);
        run_vecs(1, 24'h000001, -1, 1'b0);
        // Two vectors, matching then mismatching golden
        set_vecs(2, 1'b0, 19'h00001);
        run_vecs(2, 24'h000003, -1, 1'b0);
        run_vecs(2, 24'h000004, -1, 1'b0);
        // Zero-length run goes straight to CHECK
        set_vecs(0, 1'b0, 19'h0);
        run_vecs(0, SEED0, -1, 1'b0);
        // Long random run with idle gap and an ignored start pulse
        set_vecs(40, 1'b1, 19'h0);
        g = model_sig(40, SEED0);
        run_vecs(40, g, 2, 1'b1);

        // Reset after 3 of 5 vectors aborts the run
        set_vecs(5, 1'b1, 19'h0);
        @(negedge blif_clk_net);
        bus.start       = 1'b1;
        bus.num_vectors = 16'd5;
        bus.golden      = 24'h123456;
        @(negedge blif_clk_net);
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) accept_one(vecs[i], masks[i], ok);
        check_val("pre_rst_cnt", 32'(bus.vec_count), 32'd3);
        bus.resp_valid = 1'b1;
        blif_reset_net = 1'b1;
        @(negedge blif_clk_net);
        check_val("abort_busy", 32'(bus.busy), 32'd0);
        check_val("abort_ready", 32'(bus.resp_ready), 32'd0);
        check_val("abort_sig", 32'(bus.signature), 32'(SEED0));
        check_val("abort_cnt", 32'(bus.vec_count), 32'd0);
        check_val("abort_done", 32'(bus.done), 32'd0);
        blif_reset_net = 1'b0;
        bus.resp_valid = 1'b0;
        @(negedge blif_clk_net);
        check_val("abort_idle_done", 32'(bus.done), 32'd0);

        // Fresh run after abort, with a wrong golden
        g = model_sig(5, SEED0) ^ 24'h000010;
        run_vecs(5, g, -1, 1'b0);

        // Non-zero seed exercises the feedback taps
        @(negedge blif_clk_net);
        bus2.start       = 1'b1;
        bus2.num_vectors = 16'd1;
        bus2.golden      = 24'hC20001;
        @(negedge blif_clk_net);
        bus2.start      = 1'b0;
        bus2.resp_valid = 1'b1;
        bus2.resp_data  = 19'h0;
        t = 0;
        while (!bus2.done && t < 10) begin
            @(negedge blif_clk_net);
            t++;
        end
        bus2.resp_valid = 1'b0;
        check_val("seed_done", 32'(bus2.done), 32'd1);
        check_val("seed_sig", 32'(bus2.signature), 32'hC20001);
        check_val("seed_pass", 32'(bus2.pass), 32'd1);

`ifdef S832_RESP_XMASK_EN
        // Masked bit must not reach the signature
        vecs.delete();
        masks.delete();
        vecs.push_back(19'h00003);
        masks.push_back(19'h00002);
        check_val("mask_model", 32'(model_sig(1, SEED0)), 32'h000001);
        run_vecs(1, 24'h000001, -1, 1'b0);
`endif

        check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
